// File: rtl/pmem_arbiter.sv
// Arbitrates NUM_CH cache channels onto a single physical-memory port.
// One transaction is outstanding at a time, chosen by round-robin or fixed priority.
module pmem_arbiter #(
  parameter int unsigned NUM_CH  = 2,
  parameter int unsigned LINE_W  = 128,
  parameter int unsigned ADDR_W  = 16,
  parameter int unsigned RR_MODE = 1,
  localparam int unsigned GW     = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [NUM_CH-1:0]          ch_read,
  input  logic [NUM_CH-1:0]          ch_write,
  input  logic [NUM_CH*ADDR_W-1:0]   ch_address,
  input  logic [NUM_CH*LINE_W-1:0]   ch_wdata,
  output logic [NUM_CH-1:0]          ch_resp,
  output logic [LINE_W-1:0]          ch_rdata,
  output logic                       pmem_read,
  output logic                       pmem_write,
  output logic [ADDR_W-1:0]          pmem_address,
  output logic [LINE_W-1:0]          pmem_wdata,
  input  logic                       pmem_resp,
  input  logic [LINE_W-1:0]          pmem_rdata,
  output logic [GW-1:0]              grant_id,
  output logic                       busy
);

  typedef enum logic [0:0] {StIdle, StBusy} state_e;

  state_e              state_q, state_d;
  logic                op_write_q, op_write_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [LINE_W-1:0]   wdata_q, wdata_d;
  logic [GW-1:0]       grant_q, grant_d;
  logic [GW-1:0]       last_grant_q, last_grant_d;

  logic [NUM_CH-1:0]   req;
  logic                win_found;
  logic [GW-1:0]       win_idx;

  assign req = ch_read | ch_write;

  // Channel visited at step k of the priority scan.
  function automatic logic [GW-1:0] scan_idx(input logic [GW-1:0] last, input int unsigned k);
    int unsigned i;
    if (RR_MODE != 0) begin
      i = (32'(last) + 32'd1 + k) % NUM_CH;
    end else begin
      i = k;
    end
    return GW'(i);
  endfunction

  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    for (int unsigned k = 0; k < NUM_CH; k++) begin
      if (!win_found && req[scan_idx(last_grant_q, k)]) begin
        win_found = 1'b1;
        win_idx   = scan_idx(last_grant_q, k);
      end
    end
  end

  always_comb begin
    state_d      = state_q;
    op_write_d   = op_write_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    grant_d      = grant_q;
    last_grant_d = last_grant_q;
    unique case (state_q)
      StIdle: begin
        if (win_found) begin
          state_d    = StBusy;
          // A simultaneous read and write from the winner is served as a write.
          op_write_d = ch_write[win_idx];
          addr_d     = ch_address[win_idx*ADDR_W +: ADDR_W];
          wdata_d    = ch_wdata[win_idx*LINE_W +: LINE_W];
          grant_d    = (NUM_CH == 1) ? '0 : win_idx;
        end
      end
      StBusy: begin
        if (pmem_resp) begin
          state_d      = StIdle;
          last_grant_d = grant_q;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= StIdle;
      op_write_q   <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      grant_q      <= '0;
      last_grant_q <= GW'(NUM_CH - 1);
    end else begin
      state_q      <= state_d;
      op_write_q   <= op_write_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      grant_q      <= grant_d;
      last_grant_q <= last_grant_d;
    end
  end

  always_comb begin
    ch_resp = '0;
    if (state_q == StBusy && pmem_resp) begin
      ch_resp[grant_q] = 1'b1;
    end
  end

  assign busy         = (state_q == StBusy);
  assign pmem_read    = busy && !op_write_q;
  assign pmem_write   = busy && op_write_q;
  assign pmem_address = addr_q;
  assign pmem_wdata   = wdata_q;
  assign ch_rdata     = pmem_rdata;
  assign grant_id     = (NUM_CH == 1) ? '0 : grant_q;

endmodule

// File: tb/tb_pmem_arbiter.sv
// Directed bench: round-robin and fixed-priority two-channel arbiters plus a
// single-channel instance, all sharing the memory-side stimulus.
module tb_pmem_arbiter;

  localparam int unsigned LW = 128;
  localparam int unsigned AW = 16;

  logic           clk = 1'b0;
  logic           reset;
  logic [1:0]     ch_read, ch_write;
  logic [2*AW-1:0] ch_address;
  logic [2*LW-1:0] ch_wdata;
  logic           pmem_resp;
  logic [LW-1:0]  pmem_rdata;
  logic           one_read, one_write;

  logic [1:0]     rr_resp, fp_resp;
  logic [LW-1:0]  rr_rdata, fp_rdata, one_rdata, rr_pwdata, fp_pwdata, one_pwdata;
  logic           rr_pread, rr_pwrite, fp_pread, fp_pwrite, one_pread, one_pwrite;
  logic [AW-1:0]  rr_paddr, fp_paddr, one_paddr;
  logic [0:0]     rr_gid, fp_gid, one_gid, one_resp;
  logic           rr_busy, fp_busy, one_busy;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  pmem_arbiter #(.NUM_CH(2), .LINE_W(LW), .ADDR_W(AW), .RR_MODE(1)) dut (
    .clk(clk), .reset(reset), .ch_read(ch_read), .ch_write(ch_write),
    .ch_address(ch_address), .ch_wdata(ch_wdata), .ch_resp(rr_resp), .ch_rdata(rr_rdata),
    .pmem_read(rr_pread), .pmem_write(rr_pwrite), .pmem_address(rr_paddr),
    .pmem_wdata(rr_pwdata), .pmem_resp(pmem_resp), .pmem_rdata(pmem_rdata),
    .grant_id(rr_gid), .busy(rr_busy)
  );

  pmem_arbiter #(.NUM_CH(2), .LINE_W(LW), .ADDR_W(AW), .RR_MODE(0)) dut_fp (
    .clk(clk), .reset(reset), .ch_read(ch_read), .ch_write(ch_write),
    .ch_address(ch_address), .ch_wdata(ch_wdata), .ch_resp(fp_resp), .ch_rdata(fp_rdata),
    .pmem_read(fp_pread), .pmem_write(fp_pwrite), .pmem_address(fp_paddr),
    .pmem_wdata(fp_pwdata), .pmem_resp(pmem_resp), .pmem_rdata(pmem_rdata),
    .grant_id(fp_gid), .busy(fp_busy)
  );

  pmem_arbiter #(.NUM_CH(1), .LINE_W(LW), .ADDR_W(AW), .RR_MODE(1)) dut_one (
    .clk(clk), .reset(reset), .ch_read(one_read), .ch_write(one_write),
    .ch_address(ch_address[AW-1:0]), .ch_wdata(ch_wdata[LW-1:0]), .ch_resp(one_resp),
    .ch_rdata(one_rdata), .pmem_read(one_pread), .pmem_write(one_pwrite),
    .pmem_address(one_paddr), .pmem_wdata(one_pwdata), .pmem_resp(pmem_resp),
    .pmem_rdata(pmem_rdata), .grant_id(one_gid), .busy(one_busy)
  );

  task automatic check(input string tag, input logic [LW-1:0] got, input logic [LW-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  localparam logic [LW-1:0] A5   = {16{8'hA5}};
  localparam logic [LW-1:0] BEEF = {4{32'hDEADBEEF}};

  initial begin
    logic [0:0] rr_exp [4];
    rr_exp[0] = 1'b0; rr_exp[1] = 1'b1; rr_exp[2] = 1'b0; rr_exp[3] = 1'b1;

    reset = 1'b0; ch_read = '0; ch_write = '0; ch_address = '0; ch_wdata = '0;
    pmem_resp = 1'b0; pmem_rdata = '0; one_read = 1'b0; one_write = 1'b0;
    ch_address = {16'h0055, 16'h0077};
    ch_wdata   = {{8{16'h1111}}, {8{16'h2222}}};
    ch_read    = 2'b11;
    repeat (3) tick();
    // Requests pending while reset is held must not start anything.
    check("rst_busy", LW'(rr_busy), LW'(0));
    check("rst_pread", LW'(rr_pread), LW'(0));
    check("rst_pwrite", LW'(rr_pwrite), LW'(0));
    check("rst_gid", LW'(rr_gid), LW'(0));
    check("rst_addr", LW'(rr_paddr), LW'(0));
    check("rst_wdata", rr_pwdata, '0);
    pmem_resp = 1'b1;
    #1 check("rst_resp", LW'(rr_resp), LW'(0));
    pmem_resp = 1'b0;
    #2 reset = 1'b1;

    // Round-robin contention: first grant goes to channel 0 from reset.
    for (int i = 0; i < 4; i++) begin
      tick();
      check($sformatf("rr_gid%0d", i), LW'(rr_gid), LW'(rr_exp[i]));
      check($sformatf("rr_pread%0d", i), LW'(rr_pread), LW'(1));
      check($sformatf("rr_addr%0d", i), LW'(rr_paddr), (rr_exp[i] == 1'b1) ? LW'(16'h0055) : LW'(16'h0077));
      check($sformatf("fp_gid%0d", i), LW'(fp_gid), LW'(0));
      pmem_resp = 1'b1; pmem_rdata = LW'(i + 5);
      #1 check($sformatf("rr_resp%0d", i), LW'(rr_resp), (rr_exp[i] == 1'b1) ? LW'(2) : LW'(1));
      check($sformatf("rr_rdata%0d", i), rr_rdata, LW'(i + 5));
      tick();
      pmem_resp = 1'b0;
      #1 check($sformatf("rr_idle%0d", i), LW'(rr_busy), LW'(0));
    end
    ch_read = '0;
    tick();

    // Single read on channel 1 with a 5-cycle memory latency.
    ch_address = {16'h1230, 16'h0000};
    ch_read = 2'b10;
    tick();
    check("sr_pread", LW'(rr_pread), LW'(1));
    check("sr_pwrite", LW'(rr_pwrite), LW'(0));
    check("sr_addr", LW'(rr_paddr), LW'(16'h1230));
    check("sr_gid", LW'(rr_gid), LW'(1));
    check("sr_early_resp", LW'(rr_resp), LW'(0));
    repeat (4) tick();
    check("sr_hold", LW'(rr_pread), LW'(1));
    pmem_resp = 1'b1; pmem_rdata = A5;
    #1 check("sr_resp", LW'(rr_resp), LW'(2'b10));
    check("sr_rdata", rr_rdata, A5);
    tick();
    pmem_resp = 1'b0; ch_read = '0;
    #1 check("sr_busy_after", LW'(rr_busy), LW'(0));
    check("sr_resp_after", LW'(rr_resp), LW'(0));

    // Fixed priority: write on 0 keeps winning until it drops.
    ch_address = {16'h0B00, 16'h0A00};
    ch_write = 2'b01; ch_read = 2'b10;
    for (int i = 0; i < 3; i++) begin
      tick();
      check($sformatf("fp_win%0d", i), LW'(fp_gid), LW'(0));
      check($sformatf("fp_pwrite%0d", i), LW'(fp_pwrite), LW'(1));
      pmem_resp = 1'b1;
      #1 check($sformatf("fp_resp%0d", i), LW'(fp_resp), LW'(2'b01));
      tick();
      pmem_resp = 1'b0;
    end
    ch_write = 2'b00;
    tick();
    check("fp_ch1_gid", LW'(fp_gid), LW'(1));
    check("fp_ch1_pread", LW'(fp_pread), LW'(1));
    check("fp_ch1_addr", LW'(fp_paddr), LW'(16'h0B00));
    pmem_resp = 1'b1;
    #1 check("fp_ch1_resp", LW'(fp_resp), LW'(2'b10));
    tick();
    pmem_resp = 1'b0; ch_read = '0;
    tick();

    // Read+write on channel 0 becomes a write; withdrawal in BUSY changes nothing.
    ch_address = {16'h0000, 16'h0040};
    ch_wdata = {{LW{1'b0}}, BEEF};
    ch_write = 2'b01; ch_read = 2'b01;
    tick();
    check("wr_pwrite", LW'(rr_pwrite), LW'(1));
    check("wr_pread", LW'(rr_pread), LW'(0));
    check("wr_gid", LW'(rr_gid), LW'(0));
    ch_write = '0; ch_read = '0; ch_wdata = '1; ch_address = '1;
    repeat (2) tick();
    check("wr_hold_pwrite", LW'(rr_pwrite), LW'(1));
    check("wr_hold_wdata", rr_pwdata, BEEF);
    check("wr_hold_addr", LW'(rr_paddr), LW'(16'h0040));
    pmem_resp = 1'b1;
    #1 check("wr_resp", LW'(rr_resp), LW'(2'b01));
    tick();
    // pmem_resp stays high into IDLE: a stray response.
    check("stray_resp", LW'(rr_resp), LW'(0));
    check("stray_busy", LW'(rr_busy), LW'(0));
    tick();
    pmem_resp = 1'b0;
    check("stray_state", LW'(rr_busy), LW'(0));
    check("stray_pwrite", LW'(rr_pwrite), LW'(0));

    // Reset two cycles into a read, then re-arbitration after release.
    ch_address = {16'h0000, 16'h0100};
    ch_read = 2'b01;
    tick();
    tick();
    check("rb_pre", LW'(rr_pread), LW'(1));
    reset = 1'b0;
    #1 check("rb_pread", LW'(rr_pread), LW'(0));
    check("rb_busy", LW'(rr_busy), LW'(0));
    check("rb_addr", LW'(rr_paddr), LW'(0));
    #2 reset = 1'b1;
    tick();
    check("rb_regrant", LW'(rr_busy), LW'(1));
    check("rb_gid", LW'(rr_gid), LW'(0));
    check("rb_readdr", LW'(rr_paddr), LW'(16'h0100));
    pmem_resp = 1'b1;
    #1 check("rb_resp", LW'(rr_resp), LW'(2'b01));
    tick();
    pmem_resp = 1'b0; ch_read = '0;
    tick();

    // Single-channel instance serves every request.
    ch_address = {16'h0000, 16'h0321};
    one_write = 1'b1;
    ch_wdata = {{LW{1'b0}}, A5};
    for (int i = 0; i < 2; i++) begin
      tick();
      check($sformatf("one_busy%0d", i), LW'(one_busy), LW'(1));
      check($sformatf("one_gid%0d", i), LW'(one_gid), LW'(0));
      check($sformatf("one_pwrite%0d", i), LW'(one_pwrite), LW'(1));
      check($sformatf("one_addr%0d", i), LW'(one_paddr), LW'(16'h0321));
      pmem_resp = 1'b1;
      #1 check($sformatf("one_resp%0d", i), LW'(one_resp), LW'(1));
      tick();
      pmem_resp = 1'b0;
    end
    one_write = 1'b0;
    tick();
    check("one_idle", LW'(one_busy), LW'(0));

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
